// File: rtl/dmem_responder_if.sv
// Request/response bus between the memory pipeline stage and dmem_responder.
// The err signal exists only when DMEM_ERR_EN is defined.
interface dmem_responder_if;
  logic        req_valid;
  logic        req_write;
  logic        req_byte;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] rdata;
  logic        stall;
`ifdef DMEM_ERR_EN
  logic        err;

  modport master (
    output req_valid, req_write, req_byte, addr, wdata,
    input  req_ready, resp_valid, rdata, stall, err
  );
  modport slave (
    input  req_valid, req_write, req_byte, addr, wdata,
    output req_ready, resp_valid, rdata, stall, err
  );
`else
  modport master (
    output req_valid, req_write, req_byte, addr, wdata,
    input  req_ready, resp_valid, rdata, stall
  );
  modport slave (
    input  req_valid, req_write, req_byte, addr, wdata,
    output req_ready, resp_valid, rdata, stall
  );
`endif
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder with a fixed wait-state latency and byte/word access.
// Define DMEM_ERR_EN to flag (and suppress) misaligned word accesses via err.
module dmem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  dmem_responder_if.slave  bus
);
  localparam int         AW       = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            cap_write, cap_byte;
  logic [AW+1:0]   cap_addr;
  logic [31:0]     cap_wdata;

  logic            accept, do_access, misaligned;
  logic            op_write, op_byte;
  logic [AW+1:0]   op_addr;
  logic [31:0]     op_wdata;
  logic [AW-1:0]   idx;
  logic [1:0]      lane;
  logic [31:0]     word_rd, load_val;
  logic [31:0]     rdata_q;
  logic            err_q;
  logic            unused_addr_bits;

  logic [31:0]     mem [DEPTH_WORDS];

  assign accept           = (state_q == IDLE) && bus.req_valid;
  assign unused_addr_bits = ^bus.addr[31:AW+2];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: if (bus.req_valid) begin
        if (WAIT_CYCLES == 0) begin
          state_d = RESP;
        end else begin
          state_d = WAIT;
          cnt_d   = CNT_INIT;
        end
      end
      WAIT: if (cnt_q == 4'd0) state_d = RESP;
            else               cnt_d   = cnt_q - 4'd1;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready  = (state_q == IDLE);
    bus.resp_valid = (state_q == RESP);
    bus.stall      = (state_q == WAIT) || ((state_q == IDLE) && bus.req_valid);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cap_write <= 1'b0;
      cap_byte  <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
    end else if (accept) begin
      cap_write <= bus.req_write;
      cap_byte  <= bus.req_byte;
      cap_addr  <= bus.addr[AW+1:0];
      cap_wdata <= bus.wdata;
    end
  end

  // With zero wait cycles the access happens on the accepting edge, so the live bus is used.
  assign do_access = (state_d == RESP) && (state_q != RESP);
  assign op_write  = (state_q == IDLE) ? bus.req_write      : cap_write;
  assign op_byte   = (state_q == IDLE) ? bus.req_byte       : cap_byte;
  assign op_addr   = (state_q == IDLE) ? bus.addr[AW+1:0]   : cap_addr;
  assign op_wdata  = (state_q == IDLE) ? bus.wdata          : cap_wdata;
  assign idx       = op_addr[AW+1:2];
  assign lane      = op_addr[1:0];

`ifdef DMEM_ERR_EN
  assign misaligned = !op_byte && (lane != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  assign word_rd  = mem[idx];
  assign load_val = op_byte ? {24'd0, 8'(word_rd >> {lane, 3'b000})} : word_rd;

  // NOTE: the array has no reset; its contents must survive reset, and resetting RAM blocks is costly.
  always_ff @(posedge clk) begin
    if (reset && do_access && op_write && !misaligned) begin
      if (op_byte) mem[idx][{lane, 3'b000} +: 8] <= op_wdata[7:0];
      else         mem[idx]                      <= op_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= do_access && misaligned;
      if (do_access) rdata_q <= (op_write || misaligned) ? 32'd0 : load_val;
    end
  end

  assign bus.rdata = rdata_q;
`ifdef DMEM_ERR_EN
  assign bus.err = err_q;
`else
  logic unused_err;
  assign unused_err = err_q;
`endif
endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: directed accesses push expected responses,
// a negedge monitor pops and compares on each resp_valid pulse.
module tb_dmem_responder;
  localparam int WAITC = 2;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic clk;
  logic reset;
  int   n_total;
  int   n_pass;
  exp_t sb[$];

  dmem_responder_if bus ();
  dmem_responder_if bus0 ();

  dmem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(WAITC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  dmem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(0)) dut_w0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Monitor: every response pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b1 && bus.resp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_resp_valid", 32'(bus.resp_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        check("rdata", bus.rdata, e.rdata);
`ifdef DMEM_ERR_EN
        check("err", 32'(bus.err), 32'(e.err));
`endif
      end
    end
  end

  task automatic do_req(input logic w, input logic b, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] exp_rd, input logic exp_err);
    int edges;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_byte  = b;
    bus.addr      = a;
    bus.wdata     = d;
    #1;
    check("req_ready_idle", 32'(bus.req_ready), 32'd1);
    check("stall_idle_valid", 32'(bus.stall), 32'd1);
    sb.push_back('{rdata: exp_rd, err: exp_err});
    @(posedge clk);
    @(negedge clk);
    // Scramble the bus after acceptance: only the captured request may matter.
    bus.req_valid = 1'b0;
    bus.req_write = ~w;
    bus.req_byte  = ~b;
    bus.addr      = ~a;
    bus.wdata     = ~d;
    edges = 1;
    while (bus.resp_valid !== 1'b1 && edges < 20) begin
      check("stall_wait", 32'(bus.stall), 32'd1);
      check("ready_wait", 32'(bus.req_ready), 32'd0);
      @(negedge clk);
      edges++;
    end
    check("latency_edges", 32'(edges), 32'(WAITC + 1));
    check("stall_resp", 32'(bus.stall), 32'd0);
    check("ready_resp", 32'(bus.req_ready), 32'd0);
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    reset   = 1'b0;
    bus.req_valid  = 1'b1;
    bus.req_write  = 1'b0;
    bus.req_byte   = 1'b0;
    bus.addr       = '0;
    bus.wdata      = '0;
    bus0.req_valid = 1'b0;
    bus0.req_write = 1'b0;
    bus0.req_byte  = 1'b0;
    bus0.addr      = '0;
    bus0.wdata     = '0;

    // Reset state while reset is held low
    #12;
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_rdata", bus.rdata, 32'd0);
    check("rst_stall_valid1", 32'(bus.stall), 32'd1);
`ifdef DMEM_ERR_EN
    check("rst_err", 32'(bus.err), 32'd0);
`endif
    bus.req_valid = 1'b0;
    #1;
    check("rst_stall_valid0", 32'(bus.stall), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Word store then load, with latency and stall profile
    do_req(1'b1, 1'b0, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0);
    do_req(1'b0, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0);

    // Byte lanes, little-endian, zero-extended byte loads
    do_req(1'b1, 1'b0, 32'h20,  32'h11223344, 32'h0,        1'b0);
    do_req(1'b1, 1'b1, 32'h22,  32'h123456AA, 32'h0,        1'b0);
    do_req(1'b0, 1'b1, 32'h22,  32'h0,        32'h000000AA, 1'b0);
    do_req(1'b0, 1'b0, 32'h20,  32'h0,        32'h11AA3344, 1'b0);
    repeat (3) @(negedge clk);
    check("rdata_hold_idle", bus.rdata, 32'h11AA3344);
    do_req(1'b0, 1'b1, 32'h20,  32'h0,        32'h00000044, 1'b0);
    do_req(1'b0, 1'b1, 32'h21,  32'h0,        32'h00000033, 1'b0);
    do_req(1'b0, 1'b1, 32'h23,  32'h0,        32'h00000011, 1'b0);

    // Address wrap modulo DEPTH_WORDS*4
    do_req(1'b1, 1'b0, 32'h100, 32'h5,        32'h0,        1'b0);
    do_req(1'b0, 1'b0, 32'h0,   32'h0,        32'h5,        1'b0);
    do_req(1'b0, 1'b0, 32'hFFFF_FF00, 32'h0,  32'h5,        1'b0);

`ifdef DMEM_ERR_EN
    do_req(1'b1, 1'b0, 32'h4,   32'h01020304, 32'h0,        1'b0);
    do_req(1'b1, 1'b0, 32'h6,   32'hFFFFFFFF, 32'h0,        1'b1);
    do_req(1'b0, 1'b0, 32'h4,   32'h0,        32'h01020304, 1'b0);
    do_req(1'b0, 1'b0, 32'h23,  32'h0,        32'h0,        1'b1);
`else
    do_req(1'b0, 1'b0, 32'h23,  32'h0,        32'h11AA3344, 1'b0);
    do_req(1'b1, 1'b0, 32'h6,   32'hCAFEF00D, 32'h0,        1'b0);
    do_req(1'b0, 1'b0, 32'h4,   32'h0,        32'hCAFEF00D, 1'b0);
`endif

    // Reset pulse during WAIT drops the pending store
    do_req(1'b1, 1'b0, 32'h8,   32'h7,        32'h0,        1'b0);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_byte  = 1'b0;
    bus.addr      = 32'h8;
    bus.wdata     = 32'h99;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("stall_before_reset", 32'(bus.stall), 32'd1);
    reset = 1'b0;
    #1;
    check("async_reset_ready", 32'(bus.req_ready), 32'd1);
    #1;
    reset = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("no_resp_after_reset", 32'(bus.resp_valid), 32'd0);
    end
    check("rdata_after_reset", bus.rdata, 32'd0);
    do_req(1'b0, 1'b0, 32'h8,   32'h0,        32'h7,        1'b0);

    // Zero-wait instance with req_valid held high: accept every other cycle
    @(negedge clk);
    bus0.req_valid = 1'b1;
    bus0.req_write = 1'b1;
    bus0.addr      = 32'h4;
    bus0.wdata     = 32'h12345678;
    for (int i = 0; i < 8; i++) begin
      #1;
      check("w0_ready_alt", 32'(bus0.req_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
      check("w0_resp_alt", 32'(bus0.resp_valid), (i % 2 == 1) ? 32'd1 : 32'd0);
      check("w0_stall_alt", 32'(bus0.stall), (i % 2 == 0) ? 32'd1 : 32'd0);
      if (i == 1) begin
        check("w0_store_rdata", bus0.rdata, 32'd0);
        bus0.req_write = 1'b0;
      end
      if (i == 3) check("w0_load_rdata", bus0.rdata, 32'h12345678);
      @(negedge clk);
    end
    bus0.req_valid = 1'b0;

    repeat (2) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
